// File: rtl/cfg_pkg.sv
// Shared constants and FSM encoding for the serial configuration writer and
// the configuration register decoder that consumes its write stream.
package cfg_pkg;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 10;
    localparam int FRAME_BITS = ADDR_W + DATA_W;
    localparam int MAX_ADDR   = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        ISSUE = 2'd2
    } cfg_wr_state_e;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall detect
// against one extra delay flop.
module sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            dly  <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            dly  <= sync[SYNC_STAGES-1];
        end
    end

    assign dout = sync[SYNC_STAGES-1];
    assign rise = dout & ~dly;
    assign fall = ~dout & dly;
endmodule

// File: rtl/cfg_serial_writer.sv
// 3-wire serial frame receiver issuing single-cycle valid/addr/data register
// writes; malformed (wrong length or out-of-range address) frames are counted.
module cfg_serial_writer #(
    parameter int ADDR_W      = cfg_pkg::ADDR_W,
    parameter int DATA_W      = cfg_pkg::DATA_W,
    parameter int MAX_ADDR    = cfg_pkg::MAX_ADDR,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              sdi,
    input  logic              csn,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);
    import cfg_pkg::*;

    localparam int FRAME_LEN = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    logic sck_s, sck_rise, sck_fall;
    logic csn_s, csn_rise, csn_fall;
    logic sdi_s, sdi_unused_rise, sdi_unused_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .din(sck), .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
        .clk(clk), .rst_n(rst_n), .din(csn), .dout(csn_s), .rise(csn_rise), .fall(csn_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
        .clk(clk), .rst_n(rst_n), .din(sdi), .dout(sdi_s), .rise(sdi_unused_rise), .fall(sdi_unused_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sck_s, sck_fall, sdi_unused_rise, sdi_unused_fall};

    cfg_wr_state_e          state, state_nxt;
    logic [FRAME_LEN-1:0]   sr;
    logic [CNT_W-1:0]       cnt;
    logic                   clr, shift, go, bad;
    logic [ADDR_W-1:0]      sr_addr;

    assign sr_addr = sr[FRAME_LEN-1 -: ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The shift gate requires csn_s low, so an sck edge coinciding with the
    // closing csn edge never lands in the frame.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift     = 1'b0;
        go        = 1'b0;
        bad       = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_nxt = RECV;
                    clr       = 1'b1;
                end
            end
            RECV: begin
                if (csn_rise) begin
                    if (cnt == CNT_W'(FRAME_LEN) && 32'(sr_addr) <= $unsigned(MAX_ADDR)) begin
                        state_nxt = ISSUE;
                        go        = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        bad       = 1'b1;
                    end
                end else if (sck_rise && !csn_s) begin
                    shift = 1'b1;
                end
            end
            ISSUE: begin
                if (csn_fall) begin
                    state_nxt = RECV;
                    clr       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            valid     <= 1'b0;
            addr      <= '0;
            data      <= '0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            if (clr) begin
                sr  <= '0;
                cnt <= '0;
            end else if (shift) begin
                sr <= {sr[FRAME_LEN-2:0], sdi_s};
                // Saturating one past a full frame keeps overlong frames invalid.
                if (cnt != CNT_W'(FRAME_LEN + 1)) cnt <= cnt + 1'b1;
            end
            valid     <= go;
            frame_err <= bad;
            if (go) begin
                addr <= sr_addr;
                data <= sr[DATA_W-1:0];
            end
            if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_cfg_serial_writer.sv
// Directed bench for cfg_serial_writer: drives serial frames at the pins and
// checks the issued write stream, error pulses and error counter.
module tb_cfg_serial_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       csn = 1'b1;
    logic       valid;
    logic [4:0] addr;
    logic [9:0] data;
    logic       frame_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    localparam int PH = 6;

    cfg_serial_writer dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .csn(csn),
        .valid(valid), .addr(addr), .data(data),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: record issued writes, error pulses and protocol violations.
    logic [14:0] vq[$];
    int          nerr = 0;
    int          consec = 0;
    int          chg = 0;
    logic        prev_v = 1'b0;
    logic [14:0] prev_ad = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) vq.push_back({addr, data});
            if (frame_err) nerr++;
            if (valid && prev_v) consec++;
            if (!valid && {addr, data} != prev_ad) chg++;
        end
        prev_v  = valid;
        prev_ad = {addr, data};
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] v, input int n, input int hi);
        csn = 1'b0;
        clk_wait(PH);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = v[i];
            clk_wait(PH);
            sck = 1'b1;
            clk_wait(PH);
            sck = 1'b0;
        end
        clk_wait(PH);
        csn = 1'b1;
        clk_wait(hi);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sck = 1'b0;
        csn = 1'b1;
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk_wait(3);
        checks++;
        if ({valid, addr, data, frame_err, err_cnt} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {valid, addr, data, frame_err, err_cnt});
        end
        rst_n = 1'b1;
        clk_wait(3);
    endtask

    task automatic test_legal();
        int e0 = nerr;
        vq.delete();
        send_frame({49'd0, 5'd0, 10'h2A5}, 15, 12);
        checks++;
        if (vq.size() !== 1) begin
            failures++;
            $display("FAIL legal_count got=%0d exp=1", vq.size());
        end else begin
            checks++;
            if (vq[0] !== 15'h02A5) begin
                failures++;
                $display("FAIL legal_write got=%h exp=%h", vq[0], 15'h02A5);
            end
        end
        checks++;
        if (nerr - e0 !== 0) begin
            failures++;
            $display("FAIL legal_no_err got=%0d exp=0", nerr - e0);
        end
    endtask

    task automatic test_range();
        int e0 = nerr;
        vq.delete();
        send_frame({49'd0, 5'd27, 10'h001}, 15, 12);
        checks++;
        if (vq.size() !== 0 || nerr - e0 !== 1) begin
            failures++;
            $display("FAIL range_reject got=valids:%0d errs:%0d exp=valids:0 errs:1", vq.size(), nerr - e0);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL range_err_cnt got=%0d exp=1", err_cnt);
        end
        checks++;
        if ({addr, data} !== 15'h02A5) begin
            failures++;
            $display("FAIL range_hold got=%h exp=%h", {addr, data}, 15'h02A5);
        end
    endtask

    task automatic test_length();
        int e0;
        apply_reset();
        e0 = nerr;
        vq.delete();
        send_frame(64'h0000_0000_0000_1234, 14, 12);
        send_frame(64'h0000_0000_0000_1234, 16, 12);
        send_frame(64'h0000_0012_3456_789A, 40, 12);
        checks++;
        if (err_cnt !== 8'd3 || nerr - e0 !== 3) begin
            failures++;
            $display("FAIL length_err got=cnt:%0d pulses:%0d exp=cnt:3 pulses:3", err_cnt, nerr - e0);
        end
        checks++;
        if (vq.size() !== 0) begin
            failures++;
            $display("FAIL length_no_valid got=%0d exp=0", vq.size());
        end
    endtask

    task automatic test_back_to_back();
        int e0 = nerr;
        vq.delete();
        // One clk of csn high puts the second falling edge in the ISSUE cycle.
        send_frame({49'd0, 5'd7, 10'h03F}, 15, 1);
        send_frame({49'd0, 5'd26, 10'h00F}, 15, 12);
        checks++;
        if (vq.size() !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", vq.size());
        end else begin
            checks++;
            if (vq[0] !== {5'd7, 10'h03F} || vq[1] !== {5'd26, 10'h00F}) begin
                failures++;
                $display("FAIL b2b_values got=%h,%h exp=%h,%h", vq[0], vq[1], {5'd7, 10'h03F}, {5'd26, 10'h00F});
            end
        end
        checks++;
        if (nerr - e0 !== 0) begin
            failures++;
            $display("FAIL b2b_no_err got=%0d exp=0", nerr - e0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] part = 8'hB7;
        vq.delete();
        csn = 1'b0;
        clk_wait(PH);
        for (int i = 7; i >= 0; i--) begin
            sdi = part[i];
            clk_wait(PH);
            sck = 1'b1;
            clk_wait(PH);
            sck = 1'b0;
        end
        clk_wait(PH);
        rst_n = 1'b0;
        clk_wait(3);
        rst_n = 1'b1;
        // csn stays low through release: the re-entered frame has no bits.
        clk_wait(10);
        csn = 1'b1;
        clk_wait(12);
        checks++;
        if (vq.size() !== 0 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL midreset_partial got=valids:%0d cnt:%0d exp=valids:0 cnt:1", vq.size(), err_cnt);
        end
        send_frame({49'd0, 5'd3, 10'h001}, 15, 12);
        checks++;
        if (vq.size() !== 1 || vq[0] !== {5'd3, 10'h001}) begin
            failures++;
            $display("FAIL midreset_write got=n:%0d first:%h exp=n:1 first:%h", vq.size(),
                     (vq.size() > 0) ? vq[0] : 15'h0, {5'd3, 10'h001});
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 260; i++) begin
            csn = 1'b0;
            clk_wait(PH);
            csn = 1'b1;
            clk_wait(PH);
            if (i == 253) begin
                checks++;
                if (err_cnt !== 8'd254) begin
                    failures++;
                    $display("FAIL sat_254 got=%0d exp=254", err_cnt);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_255 got=%0d exp=255", err_cnt);
        end
    endtask

    task automatic test_simul_edge();
        logic [14:0] f = {5'd12, 10'h155};
        int e0 = nerr;
        vq.delete();
        csn = 1'b0;
        clk_wait(PH);
        for (int i = 14; i >= 0; i--) begin
            sdi = f[i];
            clk_wait(PH);
            sck = 1'b1;
            clk_wait(PH);
            sck = 1'b0;
        end
        sdi = 1'b1;
        clk_wait(PH);
        sck = 1'b1;
        csn = 1'b1;
        clk_wait(PH);
        sck = 1'b0;
        clk_wait(12);
        checks++;
        if (vq.size() !== 1 || vq[0] !== f) begin
            failures++;
            $display("FAIL simul_edge got=n:%0d first:%h exp=n:1 first:%h", vq.size(),
                     (vq.size() > 0) ? vq[0] : 15'h0, f);
        end
        checks++;
        if (nerr - e0 !== 0) begin
            failures++;
            $display("FAIL simul_no_err got=%0d exp=0", nerr - e0);
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_range();
        test_length();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        test_simul_edge();
        checks++;
        if (consec !== 0) begin
            failures++;
            $display("FAIL valid_consecutive got=%0d exp=0", consec);
        end
        checks++;
        if (chg !== 0) begin
            failures++;
            $display("FAIL addr_data_stable got=%0d exp=0", chg);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
